// File: rtl/nm_pkg.sv
// Shared types and sizes for the nibble-winner accumulator.
package nm_pkg;
  localparam int NIB_W      = 4;
  localparam int ID_W       = 2;
  localparam int NUM_LANES  = 4;
  localparam int CNT_W      = 4;
  localparam int WINDOW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACUM   = 2'd1,
    REPORT = 2'd2
  } state_e;
endpackage

// File: rtl/nm_contador.sv
// Per-ID win counter: clear (optionally loading 1 when inc is also set) or increment.
module nm_contador
  import nm_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] inc_v;

  assign inc_v = {{(CNT_W-1){1'b0}}, inc_i};

  always_comb begin
    cnt_d = cnt_q + inc_v;
    if (clr_i) cnt_d = inc_v;
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/nm_acum.sv
// Collects WINDOW valid (nibble, id) samples, tracks the earliest maximum and
// per-ID win counts, then holds a report until the consumer accepts it.
module nm_acum
  import nm_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic                         CLK,
  input  logic                         RESET_L,
  input  logic                         VALID_IN,
  input  logic [NIB_W-1:0]             NIBBLE_MAYOR,
  input  logic [ID_W-1:0]              ID_MAYOR,
  input  logic                         REPORT_READY,
  output logic                         REPORT_VALID,
  output logic [NIB_W-1:0]             REPORT_MAX,
  output logic [ID_W-1:0]              REPORT_ID,
  output logic [NUM_LANES*CNT_W-1:0]   WIN_COUNTS,
  output logic                         DROPPED
);
  localparam logic [CNT_W-1:0] WIN_L = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [NIB_W-1:0] max_q;
  logic [ID_W-1:0]  id_q;
  logic             dropped_q;

  logic                             hs;
  logic [NUM_LANES-1:0]             cnt_clr, cnt_inc;
  logic [NUM_LANES-1:0][CNT_W-1:0]  cnt;

  assign hs = (state_q == REPORT) && REPORT_READY;

  // First sample of a window reloads every counter; a handshake zeroes them.
  always_comb begin
    cnt_clr = '0;
    cnt_inc = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      cnt_clr[l] = ((state_q == IDLE) && VALID_IN) || hs;
      cnt_inc[l] = (state_q != REPORT) && VALID_IN && (ID_MAYOR == ID_W'(l));
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_cnt
    nm_contador u_cnt (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .clr_i   (cnt_clr[l]),
      .inc_i   (cnt_inc[l]),
      .cnt_o   (cnt[l])
    );
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      max_q        <= '0;
      id_q         <= '0;
      dropped_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (VALID_IN) begin
          max_q        <= NIBBLE_MAYOR;
          id_q         <= ID_MAYOR;
          sample_cnt_q <= ONE;
          state_q      <= (WIN_L == ONE) ? REPORT : ACUM;
        end
        ACUM: if (VALID_IN) begin
          sample_cnt_q <= sample_cnt_q + ONE;
          // Strict compare keeps the earliest sample on ties.
          if (NIBBLE_MAYOR > max_q) begin
            max_q <= NIBBLE_MAYOR;
            id_q  <= ID_MAYOR;
          end
          if (sample_cnt_q + ONE == WIN_L) state_q <= REPORT;
        end
        REPORT: begin
          if (VALID_IN) dropped_q <= 1'b1;
          if (REPORT_READY) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            max_q        <= '0;
            id_q         <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REPORT_VALID = (state_q == REPORT);
  assign REPORT_MAX   = REPORT_VALID ? max_q : '0;
  assign REPORT_ID    = REPORT_VALID ? id_q  : '0;
  assign WIN_COUNTS   = REPORT_VALID ? cnt   : '0;
  assign DROPPED      = dropped_q;
endmodule

// File: tb/tb_nm_acum.sv
// Self-checking bench for nm_acum: table vectors, corner sequences, random vs model.
module tb_nm_acum;
  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        VALID_IN;
  logic [3:0]  NIBBLE_MAYOR;
  logic [1:0]  ID_MAYOR;
  logic        REPORT_READY;
  logic        REPORT_VALID, DROPPED;
  logic [3:0]  REPORT_MAX;
  logic [1:0]  REPORT_ID;
  logic [15:0] WIN_COUNTS;
  logic        w1_valid, w1_drop;
  logic [3:0]  w1_max;
  logic [1:0]  w1_id;
  logic [15:0] w1_cnts;

  always #5 CLK = ~CLK;

  nm_acum dut (
    .CLK(CLK), .RESET_L(RESET_L), .VALID_IN(VALID_IN), .NIBBLE_MAYOR(NIBBLE_MAYOR),
    .ID_MAYOR(ID_MAYOR), .REPORT_READY(REPORT_READY), .REPORT_VALID(REPORT_VALID),
    .REPORT_MAX(REPORT_MAX), .REPORT_ID(REPORT_ID), .WIN_COUNTS(WIN_COUNTS),
    .DROPPED(DROPPED)
  );

  nm_acum #(.WINDOW(1)) dut1 (
    .CLK(CLK), .RESET_L(RESET_L), .VALID_IN(VALID_IN), .NIBBLE_MAYOR(NIBBLE_MAYOR),
    .ID_MAYOR(ID_MAYOR), .REPORT_READY(REPORT_READY), .REPORT_VALID(w1_valid),
    .REPORT_MAX(w1_max), .REPORT_ID(w1_id), .WIN_COUNTS(w1_cnts), .DROPPED(w1_drop)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: the window is a plain list of samples; the report is
  // derived from the whole list once it holds 8 entries.
  int          q_nib[$];
  int          q_id[$];
  bit          m_rep, m_drop;
  logic [3:0]  m_max;
  logic [1:0]  m_id;
  logic [15:0] m_cnt;

  typedef struct {
    bit v; logic [3:0] n; logic [1:0] id; bit r;
    bit ev; logic [3:0] emax; logic [1:0] eid; logic [15:0] ecnt; bit edrop;
  } vec_t;
  vec_t tbl[9];

  logic [3:0] bn[8];
  logic [1:0] bi[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q_nib.delete(); q_id.delete();
    m_rep = 0; m_drop = 0; m_max = 0; m_id = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit v, input int n, input int id, input bit r);
    int c[4];
    if (m_rep) begin
      if (v) m_drop = 1;
      if (r) begin m_rep = 0; q_nib.delete(); q_id.delete(); end
    end else if (v) begin
      q_nib.push_back(n); q_id.push_back(id);
      if (q_nib.size() == 8) begin
        m_rep = 1;
        m_max = 4'(q_nib[0]); m_id = 2'(q_id[0]);
        c = '{0, 0, 0, 0};
        foreach (q_nib[i]) begin
          if (q_nib[i] > int'(m_max)) begin m_max = 4'(q_nib[i]); m_id = 2'(q_id[i]); end
          c[q_id[i]]++;
        end
        m_cnt = {4'(c[3]), 4'(c[2]), 4'(c[1]), 4'(c[0])};
      end
    end
  endtask

  task automatic check_dut(input string tag);
    chk({tag, " valid"}, REPORT_VALID, m_rep);
    chk({tag, " max"},   REPORT_MAX,   m_rep ? m_max : 4'h0);
    chk({tag, " id"},    REPORT_ID,    m_rep ? m_id  : 2'h0);
    chk({tag, " cnts"},  WIN_COUNTS,   m_rep ? m_cnt : 16'h0);
    chk({tag, " drop"},  DROPPED,      m_drop);
  endtask

  task automatic step(input string tag, input bit v, input logic [3:0] n,
                      input logic [1:0] id, input bit r);
    VALID_IN = v; NIBBLE_MAYOR = n; ID_MAYOR = id; REPORT_READY = r;
    @(posedge CLK);
    model_edge(v, n, id, r);
    #1;
    check_dut(tag);
  endtask

  task automatic do_reset(input string tag);
    VALID_IN = 0; REPORT_READY = 0;
    RESET_L = 0;
    model_reset();
    #1;
    check_dut(tag);
    chk({tag, " w1 valid"}, w1_valid, 0);
    chk({tag, " w1 drop"},  w1_drop,  0);
    #1 RESET_L = 1;
  endtask

  initial begin
    bn = '{4'd3, 4'd9, 4'd5, 4'd9, 4'd2, 4'd7, 4'd1, 4'd4};
    bi = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0};
    // Basic window with the consumer always ready; tallies per ID are 3,2,2,1.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, bn[i], bi[i], 1'b1, 1'b0, 4'h0, 2'h0, 16'h0, 1'b0};
    tbl[7].ev = 1; tbl[7].emax = 4'h9; tbl[7].eid = 2'd2; tbl[7].ecnt = 16'h1223;
    tbl[8] = '{1'b0, 4'h0, 2'h0, 1'b1, 1'b0, 4'h0, 2'h0, 16'h0, 1'b0};

    RESET_L = 0; VALID_IN = 0; NIBBLE_MAYOR = 0; ID_MAYOR = 0; REPORT_READY = 0;
    model_reset();
    #12;
    check_dut("reset");
    RESET_L = 1;

    for (int i = 0; i < 9; i++) begin
      VALID_IN = tbl[i].v; NIBBLE_MAYOR = tbl[i].n; ID_MAYOR = tbl[i].id;
      REPORT_READY = tbl[i].r;
      @(posedge CLK);
      model_edge(tbl[i].v, tbl[i].n, tbl[i].id, tbl[i].r);
      #1;
      chk($sformatf("tbl%0d valid", i), REPORT_VALID, tbl[i].ev);
      chk($sformatf("tbl%0d max", i),   REPORT_MAX,   tbl[i].emax);
      chk($sformatf("tbl%0d id", i),    REPORT_ID,    tbl[i].eid);
      chk($sformatf("tbl%0d cnts", i),  WIN_COUNTS,   tbl[i].ecnt);
      chk($sformatf("tbl%0d drop", i),  DROPPED,      tbl[i].edrop);
    end

    // Backpressure: report held for 5 cycles while two samples are dropped.
    for (int i = 0; i < 8; i++) step("bp fill", 1, bn[i], bi[i], 0);
    for (int c = 0; c < 5; c++) begin
      step("bp hold", (c == 1 || c == 3), 4'hF, 2'd3, 0);
      chk("bp stable valid", REPORT_VALID, 1);
      chk("bp stable max",   REPORT_MAX,   4'h9);
      chk("bp stable id",    REPORT_ID,    2'd2);
      chk("bp stable cnts",  WIN_COUNTS,   16'h1223);
      chk("bp drop",         DROPPED,      (c >= 1));
    end
    step("bp hs", 0, 0, 0, 1);
    chk("bp hs valid", REPORT_VALID, 0);
    // Next window, all ties on ID 1, must start clean.
    for (int i = 0; i < 8; i++) step("ties", 1, 4'h0, 2'd1, 0);
    chk("ties valid", REPORT_VALID, 1);
    chk("ties max",   REPORT_MAX,   4'h0);
    chk("ties id",    REPORT_ID,    2'd1);
    chk("ties cnts",  WIN_COUNTS,   16'h0080);
    chk("ties drop sticky", DROPPED, 1);
    step("ties hs", 0, 0, 0, 1);

    // Gaps: alternating valid, report exactly after the 8th valid sample.
    do_reset("gap rst");
    for (int c = 0; c < 16; c++) begin
      step("gap", (c % 2 == 0), bn[c/2], bi[c/2], 0);
      chk($sformatf("gap%0d valid", c), REPORT_VALID, (c >= 14));
    end
    chk("gap cnts", WIN_COUNTS, 16'h1223);
    step("gap hs", 0, 0, 0, 1);

    // Reset mid-window discards the partial window.
    for (int i = 0; i < 4; i++) step("mid", 1, 4'hF, 2'd3, 0);
    do_reset("mid rst");
    for (int i = 0; i < 8; i++) step("mid after", 1, bn[i], bi[i], 0);
    chk("mid max",  REPORT_MAX, 4'h9);
    chk("mid id",   REPORT_ID,  2'd2);
    chk("mid cnts", WIN_COUNTS, 16'h1223);

    // Reset while a report is pending abandons it.
    do_reset("rep rst");

    // WINDOW=1 instance.
    step("w1", 1, 4'hF, 2'd3, 0);
    chk("w1 valid", w1_valid, 1);
    chk("w1 max",   w1_max,   4'hF);
    chk("w1 id",    w1_id,    2'd3);
    chk("w1 cnts",  w1_cnts,  16'h1000);
    step("w1 hs", 0, 0, 0, 1);
    chk("w1 hs valid", w1_valid, 0);
    chk("w1 hs cnts",  w1_cnts,  16'h0);

    // Random traffic against the model.
    do_reset("rnd rst");
    for (int c = 0; c < 400; c++)
      step("rnd", ($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
